// File: rtl/denormalization_shifter.sv
// ---------------------------------------------------------------------------
// denormalization_shifter
//
// Undoes normalization. The block takes a normalized vector and its
// leading-zero count, then shifts the vector right by that count, one bit
// position per clock. The MSB is zero-filled. A sticky bit collects the OR
// of every bit that falls off the LSB end.
//
// A count above DATA_W is saturated to DATA_W, and the clipped output flags
// that this happened. One transaction is in flight at a time.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   input transaction present
//   in_ready   block can accept an input (high only when idle)
//   vector     normalized data to denormalize
//   zero_num   right-shift amount (leading-zero count format)
//   out_valid  result present (held until out_ready)
//   out_ready  consumer accepts result
//   data_out   vector shifted right by the effective count
//   sticky     OR of all bits shifted out
//   clipped    zero_num exceeded DATA_W and was saturated
// ---------------------------------------------------------------------------
module denormalization_shifter #(
   parameter int DATA_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         vector,
   input  logic [$clog2(DATA_W):0]   zero_num,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         data_out,
   output logic                      sticky,
   output logic                      clipped
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] MAX_SHIFT = CNT_W'(DATA_W);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] data_q;
   logic              sticky_q;
   logic              clipped_q;
   logic [CNT_W-1:0]  count_q;
   logic              accept;
   logic [CNT_W-1:0]  eff;

   // Clamp the requested shift to the vector width. A larger shift gives the
   // same result as shifting by DATA_W.
   function automatic logic [CNT_W-1:0] sat_shift(input logic [CNT_W-1:0] zn);
      return (zn > MAX_SHIFT) ? MAX_SHIFT : zn;
   endfunction

   assign eff       = sat_shift(zero_num);
   assign in_ready  = (state == IDLE);
   assign accept    = in_valid && (state == IDLE);
   // out_valid decodes the state register directly, so it is glitch-free.
   // It has no combinational path from any input.
   assign out_valid = (state == DONE);
   assign data_out  = data_q;
   assign sticky    = sticky_q;
   assign clipped   = clipped_q;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept) state_nxt = (eff != '0) ? SHIFT : DONE;
         SHIFT: if (count_q == CNT_W'(1)) state_nxt = DONE;
         DONE:  if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q    <= '0;
         sticky_q  <= 1'b0;
         clipped_q <= 1'b0;
         count_q   <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               data_q    <= vector;
               sticky_q  <= 1'b0;
               clipped_q <= (zero_num > MAX_SHIFT);
               count_q   <= eff;
            end
            SHIFT: begin
               data_q   <= data_q >> 1;
               sticky_q <= sticky_q | data_q[0];
               count_q  <= count_q - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_denormalization_shifter.sv
module tb_denormalization_shifter;

   localparam int DATA_W = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] vector;
   logic [3:0] zero_num;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] data_out;
   logic       sticky;
   logic       clipped;

   denormalization_shifter #(.DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .vector(vector), .zero_num(zero_num), .out_valid(out_valid),
      .out_ready(out_ready), .data_out(data_out), .sticky(sticky),
      .clipped(clipped)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] vec;
      logic [3:0] zn;
      logic [7:0] data;
      logic       stk;
      logic       clp;
      int         lat;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       stk;
      logic       clp;
      int         lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: shift by the clamped count in one step.
   function automatic vec_t model(input logic [7:0] v, input logic [3:0] zn);
      vec_t r;
      int   eff;
      logic [15:0] mask;
      eff   = (int'(zn) > DATA_W) ? DATA_W : int'(zn);
      mask  = (16'd1 << eff) - 16'd1;
      r.vec = v;
      r.zn  = zn;
      r.data = 8'(16'(v) >> eff);
      r.stk  = |(16'(v) & mask);
      r.clp  = (int'(zn) > DATA_W);
      r.lat  = eff + 1;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for in_ready, present one input and push its expectation at the
   // accepting edge. Then wait for out_valid, measure the latency and compare.
   task automatic run_txn(input vec_t t, input string tag);
      int   n;
      exp_t e;
      n = 0;
      while (!in_ready && n < 50) begin tick(); n++; end
      check({tag, " in_ready before accept"}, in_ready, 1);
      in_valid = 1'b1;
      vector   = t.vec;
      zero_num = t.zn;
      @(posedge clk);
      sb_q.push_back('{t.data, t.stk, t.clp, t.lat});
      #1;
      in_valid = 1'b0;
      check({tag, " in_ready after accept"}, in_ready, 0);
      n = 1;
      while (!out_valid && n < 40) begin tick(); n++; end
      check({tag, " latency"}, n, t.lat);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, " data_out"}, data_out, e.data);
         check({tag, " sticky"},   sticky,   e.stk);
         check({tag, " clipped"},  clipped,  e.clp);
      end
      tick();
      check({tag, " out_valid drop"}, out_valid, 0);
      check({tag, " in_ready return"}, in_ready, 1);
   endtask

   vec_t tbl[9];

   initial begin
      logic [7:0] held_data;
      logic       held_stk;
      int         seen;
      int         n;

      tbl[0] = '{8'hB0, 4'd3,  8'h16, 1'b0, 1'b0, 4};
      tbl[1] = '{8'h87, 4'd2,  8'h21, 1'b1, 1'b0, 3};
      tbl[2] = '{8'hA5, 4'd0,  8'hA5, 1'b0, 1'b0, 1};
      tbl[3] = '{8'h81, 4'd12, 8'h00, 1'b1, 1'b1, 9};
      tbl[4] = '{8'h00, 4'd8,  8'h00, 1'b0, 1'b0, 9};
      tbl[5] = '{8'hFF, 4'd15, 8'h00, 1'b1, 1'b1, 9};
      tbl[6] = '{8'h01, 4'd1,  8'h00, 1'b1, 1'b0, 2};
      tbl[7] = '{8'h80, 4'd7,  8'h01, 1'b0, 1'b0, 8};
      tbl[8] = '{8'hC3, 4'd9,  8'h00, 1'b1, 1'b1, 9};

      rst = 1'b1; in_valid = 1'b0; vector = '0; zero_num = '0; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("reset in_ready",  in_ready,  1);
      check("reset out_valid", out_valid, 0);
      check("reset data_out",  data_out,  0);
      check("reset sticky",    sticky,    0);
      check("reset clipped",   clipped,   0);

      for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 10; i++)
         run_txn(model(8'($urandom), 4'($urandom_range(0, 15))), $sformatf("rnd%0d", i));

      // Backpressure: the result is held for 5 cycles while a second input waits.
      out_ready = 1'b0;
      in_valid = 1'b1; vector = 8'hF0; zero_num = 4'd4;
      @(posedge clk); #1;
      vector = 8'h0F; zero_num = 4'd1;
      n = 1;
      while (!out_valid && n < 40) begin tick(); n++; end
      check("bp latency", n, 5);
      check("bp data", data_out, 8'h0F);
      check("bp sticky", sticky, 0);
      held_data = data_out;
      held_stk  = sticky;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp out_valid held", out_valid, 1);
         check("bp data held", data_out, held_data);
         check("bp sticky held", sticky, held_stk);
         check("bp in_ready low", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      check("bp out_valid drop", out_valid, 0);
      check("bp idle in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("bp second accepted", in_ready, 0);
      n = 1;
      while (!out_valid && n < 40) begin tick(); n++; end
      check("bp second latency", n, 2);
      check("bp second data", data_out, 8'h07);
      check("bp second sticky", sticky, 1);
      check("bp second clipped", clipped, 0);
      tick();

      // Reset during the third SHIFT cycle of a 6-bit shift.
      in_valid = 1'b1; vector = 8'hFF; zero_num = 4'd6;
      @(posedge clk); #1;
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst out_valid", out_valid, 0);
      check("rst data_out", data_out, 0);
      check("rst sticky", sticky, 0);
      check("rst clipped", clipped, 0);
      check("rst in_ready", in_ready, 1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check("rst no stale result", seen, 0);

      run_txn(tbl[0], "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/denormalization_shifter.md
Name: denormalization_shifter

Overview:
- Inverse of the normalization path. Takes a normalized vector and its leading-zero count, and restores the original alignment by shifting right by that count.
- Also produces a sticky bit: the OR of all bits shifted out.
- Iterative design, one bit position per clock, with valid/ready handshakes on both the input and output sides.
- Sits after the arithmetic stage that consumed the normalized operand, in the normalization module group.

Parameters:
- DATA_W, 8, width of data vector in bits (>= 2).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input transaction present
- in_ready  output  1  block can accept an input
- vector  input  DATA_W  normalized data to denormalize
- zero_num  input  $clog2(DATA_W)+1  right-shift amount (leading-zero count format)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- data_out  output  DATA_W  vector shifted right by effective count, zero-filled from MSB
- sticky  output  1  OR of all bits shifted out
- clipped  output  1  zero_num exceeded DATA_W and was saturated

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE; out_valid=0; data_out=0; sticky=0; clipped=0; internal count=0. in_ready=1 in the cycle after reset deasserts.
- States: IDLE, SHIFT, DONE.
- in_ready: combinational, equal to (state==IDLE). It is never high in SHIFT or DONE.
- out_valid: registered, high only in DONE.
- Accept rule: an input is accepted on a rising edge with in_valid & in_ready. On accept:
  - data register <= vector; sticky <= 0.
  - eff = min(zero_num, DATA_W); count <= eff.
  - clipped <= (zero_num > DATA_W).
  - Next state: SHIFT if eff != 0, else DONE.
- SHIFT, each cycle:
  - data <= data >> 1 (MSB filled with 0).
  - sticky <= sticky | data[0].
  - count <= count - 1.
  - When count==1, next state is DONE.
- DONE:
  - out_valid=1.
  - data_out, sticky and clipped are held stable while out_ready=0.
  - On out_valid & out_ready, next state is IDLE and out_valid drops the next cycle.
  - No new input is accepted in the same cycle as output consumption. The earliest next accept is the cycle after return to IDLE.
- Latency: out_valid asserts exactly eff+1 cycles after the accepting edge. Range is 1 (eff=0) to DATA_W+1.
- Throughput: one transaction per eff+3 cycles minimum. Inputs are not pipelined.
- Boundary, eff=DATA_W: data_out=0 and sticky=|vector.
- Boundary, vector=0: data_out=0 and sticky=0 for any count.
- In DONE, data_out equals the internal data register.
- Reset mid-operation (any state): rst has priority. The in-flight transaction is discarded with no out_valid pulse, and all outputs return to reset values on the next edge.
- in_valid while busy: ignored. The upstream source must hold in_valid/vector/zero_num until in_ready.
- No X propagation: outputs are defined at all times after the first reset edge.

Test Plan (DATA_W=8, zero_num 4 bits):
- Basic shift: vector=8'b1011_0000, zero_num=3 -> out_valid in 4th cycle after accept, data_out=8'b0001_0110, sticky=0, clipped=0.
- Sticky: vector=8'b1000_0111, zero_num=2 -> data_out=8'b0010_0001, sticky=1, out_valid after 3 cycles.
- Zero shift: vector=8'hA5, zero_num=0 -> out_valid 1 cycle after accept, data_out=8'hA5, sticky=0. With out_ready=1, in_ready returns high 2 cycles after accept.
- Saturation and clipping:
  - vector=8'h81, zero_num=12 -> eff=8, data_out=8'h00, sticky=1, clipped=1, out_valid 9 cycles after accept.
  - zero_num=8 with vector=8'h00 -> data_out=0, sticky=0, clipped=0.
- Backpressure: out_ready=0 for 5 cycles in DONE.
  - out_valid stays 1 and data_out/sticky stay constant.
  - in_ready stays 0 and a second in_valid is not accepted.
  - Release out_ready -> one handshake, IDLE next cycle, then the second input is accepted.
- Reset mid-SHIFT: accept zero_num=6, assert rst in 3rd SHIFT cycle -> next cycle state IDLE, out_valid=0, data_out=0, sticky=0, in_ready=1. No result is ever emitted for the aborted input.
